// File: rtl/spi_wb_regs_if.sv
// Wishbone slave bus bundle for the SPI register front end.
//   wb_adr_i  byte address, [4:2] selects the register word
//   wb_dat_i  write data          wb_dat_o  registered read data
//   wb_sel_i  byte-lane enables   wb_we_i   write enable
//   wb_stb_i  strobe              wb_cyc_i  bus cycle
//   wb_ack_o  acknowledge         wb_err_o  error response
//   wb_int_o  transfer-done interrupt
interface spi_wb_regs_if;
   logic [4:0]  wb_adr_i;
   logic [31:0] wb_dat_i;
   logic [31:0] wb_dat_o;
   logic [3:0]  wb_sel_i;
   logic        wb_we_i;
   logic        wb_stb_i;
   logic        wb_cyc_i;
   logic        wb_ack_o;
   logic        wb_err_o;
   logic        wb_int_o;

   modport slave (
      input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_stb_i, wb_cyc_i,
      output wb_dat_o, wb_ack_o, wb_err_o, wb_int_o
   );

   modport master (
      output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_stb_i, wb_cyc_i,
      input  wb_dat_o, wb_ack_o, wb_err_o, wb_int_o
   );
endinterface

// File: rtl/spi_wb_regs.sv
// Wishbone register file and transfer control for the SPI master core.
// Holds TX/RX data words, CTRL, DIVIDER and SS, and runs the go/busy/done
// handshake toward the shift engine.
//
// Ports:
//   wb_clk_i, wb_rst_ni   clock, asynchronous active-low reset
//   wb                    Wishbone slave bundle (spi_wb_regs_if.slave)
//   go_o                  one-cycle start pulse to the shift engine
//   char_len_o            bits per transfer (0 = 128)
//   lsb_o/tx_neg_o/rx_neg_o  CTRL mode bits
//   divider_o             SCLK divider
//   tx_data_o             transmit data, word0 in [31:0]
//   rx_data_i, done_i     receive data and its one-cycle completion strobe
//   ss_pad_o              slave selects, active low
//
// Build option: define SPI_WB_ERR_EN to answer accesses to 0x1C or to a
// misaligned address with wb_err_o instead of wb_ack_o.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no transfer; DATA/CTRL/DIVIDER writable
// ST_START | go_o high for this cycle, GO_BSY reads 1
// ST_BUSY  | waiting for done_i from the engine
module spi_wb_regs #(
   parameter int SS_NB  = 8,
   parameter int DIV_W  = 16,
   parameter int DATA_W = 128
) (
   input  logic                wb_clk_i,
   input  logic                wb_rst_ni,
   spi_wb_regs_if.slave        wb,
   output logic                go_o,
   output logic [6:0]          char_len_o,
   output logic                lsb_o,
   output logic                tx_neg_o,
   output logic                rx_neg_o,
   output logic [DIV_W-1:0]    divider_o,
   output logic [DATA_W-1:0]   tx_data_o,
   input  logic [DATA_W-1:0]   rx_data_i,
   input  logic                done_i,
   output logic [SS_NB-1:0]    ss_pad_o
);

`ifdef SPI_WB_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_BUSY  = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic               ack_q, ack_d;
   logic               err_q, err_d;
   logic               int_q, int_d;
   logic [31:0]        dat_q, dat_d;
   logic [3:0][31:0]   tx_q, tx_d;
   logic [3:0][31:0]   rx_q, rx_d;
   logic [6:0]         char_len_q, char_len_d;
   logic               rx_neg_q, rx_neg_d;
   logic               tx_neg_q, tx_neg_d;
   logic               lsb_q, lsb_d;
   logic               ie_q, ie_d;
   logic               ass_q, ass_d;
   logic [DIV_W-1:0]   div_q, div_d;
   logic [SS_NB-1:0]   ss_q, ss_d;

   logic               access;
   logic               bad_adr;
   logic               busy;
   logic               wr;
   logic [2:0]         word;
   logic [31:0]        ctrl_rd;
   logic [31:0]        rd_mux;

   function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  sel);
      logic [31:0] res;
      for (int i = 0; i < 4; i++) begin
         res[i*8 +: 8] = sel[i] ? new_v[i*8 +: 8] : old_v[i*8 +: 8];
      end
      return res;
   endfunction

   always_comb begin
      access  = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q & ~err_q;
      word    = wb.wb_adr_i[4:2];
      // 0x1C and any sub-word address are never register accesses.
      bad_adr = (word == 3'd7) | (wb.wb_adr_i[1:0] != 2'b00);
      busy    = (state_q != ST_IDLE);
      wr      = access & wb.wb_we_i & ~bad_adr;

      ctrl_rd        = '0;
      ctrl_rd[6:0]   = char_len_q;
      ctrl_rd[8]     = busy;
      ctrl_rd[9]     = rx_neg_q;
      ctrl_rd[10]    = tx_neg_q;
      ctrl_rd[11]    = lsb_q;
      ctrl_rd[12]    = ie_q;
      ctrl_rd[13]    = ass_q;

      case (word)
         3'd0, 3'd1, 3'd2, 3'd3: rd_mux = rx_q[word[1:0]];
         3'd4:                   rd_mux = ctrl_rd;
         3'd5:                   rd_mux = 32'(div_q);
         3'd6:                   rd_mux = 32'(ss_q);
         default:                rd_mux = '0;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      ack_d      = 1'b0;
      err_d      = 1'b0;
      int_d      = int_q;
      dat_d      = '0;
      tx_d       = tx_q;
      rx_d       = rx_q;
      char_len_d = char_len_q;
      rx_neg_d   = rx_neg_q;
      tx_neg_d   = tx_neg_q;
      lsb_d      = lsb_q;
      ie_d       = ie_q;
      ass_d      = ass_q;
      div_d      = div_q;
      ss_d       = ss_q;
      go_o       = 1'b0;

      ack_d = access & ~(bad_adr & ERR_EN);
      err_d = access & bad_adr & ERR_EN;

      if (access & ~wb.wb_we_i & ~bad_adr) begin
         dat_d = rd_mux;
      end

      if (ack_d) begin
         int_d = 1'b0;
      end

      if (wr) begin
         case (word)
            3'd0, 3'd1, 3'd2, 3'd3: begin
               if (!busy) begin
                  tx_d[word[1:0]] = lane_merge(tx_q[word[1:0]], wb.wb_dat_i, wb.wb_sel_i);
               end
            end
            3'd4: begin
               if (!busy) begin
                  if (wb.wb_sel_i[0]) begin
                     char_len_d = wb.wb_dat_i[6:0];
                  end
                  if (wb.wb_sel_i[1]) begin
                     rx_neg_d = wb.wb_dat_i[9];
                     tx_neg_d = wb.wb_dat_i[10];
                     lsb_d    = wb.wb_dat_i[11];
                     ie_d     = wb.wb_dat_i[12];
                     ass_d    = wb.wb_dat_i[13];
                     if (wb.wb_dat_i[8]) begin
                        state_d = ST_START;
                     end
                  end
               end
            end
            3'd5: begin
               if (!busy) begin
                  for (int i = 0; i < DIV_W; i++) begin
                     if (wb.wb_sel_i[i/8]) div_d[i] = wb.wb_dat_i[i];
                  end
               end
            end
            3'd6: begin
               for (int i = 0; i < SS_NB; i++) begin
                  if (wb.wb_sel_i[i/8]) ss_d[i] = wb.wb_dat_i[i];
               end
            end
            default: ;
         endcase
      end

      case (state_q)
         ST_START: begin
            go_o    = 1'b1;
            state_d = ST_BUSY;
         end
         ST_BUSY: begin
            if (done_i) begin
               rx_d    = rx_data_i;
               state_d = ST_IDLE;
               // Set after the clear above so a coinciding access loses.
               if (ie_q) int_d = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state_q    <= ST_IDLE;
         ack_q      <= 1'b0;
         err_q      <= 1'b0;
         int_q      <= 1'b0;
         dat_q      <= '0;
         tx_q       <= '0;
         rx_q       <= '0;
         char_len_q <= '0;
         rx_neg_q   <= 1'b0;
         tx_neg_q   <= 1'b0;
         lsb_q      <= 1'b0;
         ie_q       <= 1'b0;
         ass_q      <= 1'b0;
         div_q      <= '0;
         ss_q       <= '0;
      end else begin
         state_q    <= state_d;
         ack_q      <= ack_d;
         err_q      <= err_d;
         int_q      <= int_d;
         dat_q      <= dat_d;
         tx_q       <= tx_d;
         rx_q       <= rx_d;
         char_len_q <= char_len_d;
         rx_neg_q   <= rx_neg_d;
         tx_neg_q   <= tx_neg_d;
         lsb_q      <= lsb_d;
         ie_q       <= ie_d;
         ass_q      <= ass_d;
         div_q      <= div_d;
         ss_q       <= ss_d;
      end
   end

   assign wb.wb_ack_o = ack_q;
   assign wb.wb_err_o = err_q;
   assign wb.wb_int_o = int_q;
   assign wb.wb_dat_o = dat_q;
   assign char_len_o  = char_len_q;
   assign lsb_o       = lsb_q;
   assign tx_neg_o    = tx_neg_q;
   assign rx_neg_o    = rx_neg_q;
   assign divider_o   = div_q;
   assign tx_data_o   = tx_q;
   // With ASS set, the selects follow the transfer window automatically.
   assign ss_pad_o    = ass_q ? ~(ss_q & {SS_NB{busy}}) : ~ss_q;

endmodule

// File: tb/tb_spi_wb_regs.sv
module tb_spi_wb_regs;

`ifdef SPI_WB_ERR_EN
   localparam bit ERR = 1'b1;
`else
   localparam bit ERR = 1'b0;
`endif

   logic         clk;
   logic         rst_n;
   logic         go;
   logic [6:0]   char_len;
   logic         lsb, tx_neg, rx_neg;
   logic [15:0]  divider;
   logic [127:0] tx_data;
   logic [127:0] rx_data;
   logic         done;
   logic [7:0]   ss_pad;

   spi_wb_regs_if bus();

   spi_wb_regs #(.SS_NB(8), .DIV_W(16), .DATA_W(128)) dut (
      .wb_clk_i   (clk),
      .wb_rst_ni  (rst_n),
      .wb         (bus),
      .go_o       (go),
      .char_len_o (char_len),
      .lsb_o      (lsb),
      .tx_neg_o   (tx_neg),
      .rx_neg_o   (rx_neg),
      .divider_o  (divider),
      .tx_data_o  (tx_data),
      .rx_data_i  (rx_data),
      .done_i     (done),
      .ss_pad_o   (ss_pad)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;

   // Reference model: architectural register contents only.
   logic [31:0] m_tx [4];
   logic [31:0] m_rx [4];
   logic [6:0]  m_cl;
   logic        m_rxn, m_txn, m_lsb, m_ie, m_ass;
   logic        m_busy, m_int;
   logic [15:0] m_div;
   logic [7:0]  m_ss;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] lanes(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
      logic [31:0] r;
      for (int i = 0; i < 4; i++) r[i*8 +: 8] = s[i] ? n[i*8 +: 8] : o[i*8 +: 8];
      return r;
   endfunction

   function automatic logic is_bad(input logic [4:0] adr);
      return (adr[4:2] == 3'd7) || (adr[1:0] != 2'b00);
   endfunction

   function automatic logic [31:0] m_ctrl();
      return {18'b0, m_ass, m_ie, m_lsb, m_txn, m_rxn, m_busy, 1'b0, m_cl};
   endfunction

   function automatic logic [31:0] m_read(input logic [4:0] adr);
      int w = int'(adr[4:2]);
      if (is_bad(adr)) return 32'h0;
      if (w < 4) return m_rx[w];
      if (w == 4) return m_ctrl();
      if (w == 5) return {16'h0, m_div};
      return {24'h0, m_ss};
   endfunction

   task automatic m_write(input logic [4:0] adr, input logic [31:0] d, input logic [3:0] s);
      int w = int'(adr[4:2]);
      logic [31:0] c;
      if (is_bad(adr)) return;
      if (w < 4) begin
         if (!m_busy) m_tx[w] = lanes(m_tx[w], d, s);
      end else if (w == 4) begin
         if (!m_busy) begin
            c = lanes(m_ctrl(), d, s);
            m_cl = c[6:0]; m_rxn = c[9]; m_txn = c[10];
            m_lsb = c[11]; m_ie = c[12]; m_ass = c[13];
            if (s[1] && d[8]) m_busy = 1'b1;
         end
      end else if (w == 5) begin
         if (!m_busy) begin
            c = lanes({16'h0, m_div}, d, s);
            m_div = c[15:0];
         end
      end else begin
         c = lanes({24'h0, m_ss}, d, s);
         m_ss = c[7:0];
      end
   endtask

   task automatic m_reset();
      for (int i = 0; i < 4; i++) begin m_tx[i] = '0; m_rx[i] = '0; end
      m_cl = '0; m_rxn = 0; m_txn = 0; m_lsb = 0; m_ie = 0; m_ass = 0;
      m_busy = 0; m_int = 0; m_div = '0; m_ss = '0;
   endtask

   function automatic logic [7:0] m_sspad();
      return m_ass ? ~(m_ss & {8{m_busy}}) : ~m_ss;
   endfunction

   task automatic bus_cyc(input logic [4:0] adr, input logic we, input logic [31:0] d,
                          input logic [3:0] s, output logic [31:0] rd, output logic a,
                          output logic e, output logic g, output logic irq);
      @(negedge clk);
      bus.wb_adr_i = adr; bus.wb_we_i = we; bus.wb_dat_i = d; bus.wb_sel_i = s;
      bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1;
      @(posedge clk); #1;
      a = bus.wb_ack_o; e = bus.wb_err_o; rd = bus.wb_dat_o; g = go; irq = bus.wb_int_o;
      @(negedge clk);
      bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
   endtask

   task automatic wr_chk(input logic [4:0] adr, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] rd;
      logic a, e, g, irq, was_busy, errp;
      errp = is_bad(adr) && ERR;
      was_busy = m_busy;
      bus_cyc(adr, 1'b1, d, s, rd, a, e, g, irq);
      chk("wr_ack", a, !errp);
      chk("wr_err", e, errp);
      if (!errp) m_int = 1'b0;
      m_write(adr, d, s);
      chk("wr_go", g, !was_busy && m_busy);
      chk("wr_int", irq, m_int);
   endtask

   task automatic rd_chk(input logic [4:0] adr);
      logic [31:0] rd, exp;
      logic a, e, g, irq, errp;
      errp = is_bad(adr) && ERR;
      exp = m_read(adr);
      bus_cyc(adr, 1'b0, 32'h0, 4'hF, rd, a, e, g, irq);
      chk("rd_ack", a, !errp);
      chk("rd_err", e, errp);
      chk("rd_data", rd, exp);
      if (!errp) m_int = 1'b0;
      chk("rd_int", irq, m_int);
   endtask

   task automatic done_pulse(input logic [127:0] d);
      @(negedge clk);
      chk("go_quiet", go, 1'b0);
      done = 1'b1; rx_data = d;
      @(posedge clk); #1;
      if (m_busy) begin
         for (int i = 0; i < 4; i++) m_rx[i] = d[i*32 +: 32];
         m_busy = 1'b0;
         if (m_ie) m_int = 1'b1;
      end
      chk("done_int", bus.wb_int_o, m_int);
      chk("done_ss", ss_pad, m_sspad());
      @(negedge clk);
      done = 1'b0;
   endtask

   task automatic chk_outs();
      chk("char_len", char_len, m_cl);
      chk("lsb", lsb, m_lsb);
      chk("tx_neg", tx_neg, m_txn);
      chk("rx_neg", rx_neg, m_rxn);
      chk("divider", divider, m_div);
      chk("tx_data", tx_data, {m_tx[3], m_tx[2], m_tx[1], m_tx[0]});
      chk("ss_pad", ss_pad, m_sspad());
   endtask

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   initial begin
      logic [31:0]  exp, d;
      logic [127:0] r;
      logic [4:0]   adr;
      int           op;

      bus.wb_adr_i = '0; bus.wb_dat_i = '0; bus.wb_sel_i = '0;
      bus.wb_we_i = 0; bus.wb_stb_i = 0; bus.wb_cyc_i = 0;
      done = 0; rx_data = '0;
      m_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ack", bus.wb_ack_o, 1'b0);
      chk("rst_err", bus.wb_err_o, 1'b0);
      chk("rst_int", bus.wb_int_o, 1'b0);
      chk("rst_go", go, 1'b0);
      chk("rst_dat", bus.wb_dat_o, 32'h0);
      chk_outs();
      @(negedge clk);
      rst_n = 1'b1;

      rd_chk(5'h10);

      // DIVIDER byte-lane write
      wr_chk(5'h14, 32'h0000_1234, 4'hF);
      wr_chk(5'h14, 32'h0000_0003, 4'b0001);
      chk("div_lane_model", m_div, 16'h1203);
      rd_chk(5'h14);

      // back-to-back: stb held for three edges -> ack, idle, ack
      exp = m_read(5'h14);
      @(negedge clk);
      bus.wb_adr_i = 5'h14; bus.wb_we_i = 0; bus.wb_sel_i = 4'hF;
      bus.wb_cyc_i = 1; bus.wb_stb_i = 1;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         chk("b2b_ack", bus.wb_ack_o, k != 1);
         if (k != 1) chk("b2b_data", bus.wb_dat_o, exp);
      end
      @(negedge clk);
      bus.wb_cyc_i = 0; bus.wb_stb_i = 0;
      m_int = 1'b0;

      // basic transfer with interrupt
      wr_chk(5'h00, 32'hA5A5_A5A5, 4'hF);
      wr_chk(5'h10, 32'h0000_1108, 4'hF);
      rd_chk(5'h10);
      wr_chk(5'h14, 32'h0000_0007, 4'hF);   // ignored while busy
      rd_chk(5'h14);
      rd_chk(5'h00);                          // previous RX while busy
      chk_outs();
      done_pulse({96'h0, 32'h0000_003C});
      rd_chk(5'h00);                          // this access clears the interrupt
      rd_chk(5'h10);
      chk_outs();

      // ASS window on ss_pad
      wr_chk(5'h18, 32'h0000_0004, 4'hF);
      wr_chk(5'h10, 32'h0000_2008, 4'hF);     // ASS=1, no go
      chk("ass_idle", ss_pad, 8'hFF);
      wr_chk(5'h10, 32'h0000_3108, 4'hF);     // ASS, IE, GO
      chk("ass_busy", ss_pad, 8'hFB);
      rd_chk(5'h10);
      chk("ass_busy2", ss_pad, 8'hFB);
      // done coinciding with an access: the interrupt set wins
      r = rand128();
      exp = m_read(5'h10);
      @(negedge clk);
      bus.wb_adr_i = 5'h10; bus.wb_we_i = 0; bus.wb_sel_i = 4'hF;
      bus.wb_cyc_i = 1; bus.wb_stb_i = 1; done = 1; rx_data = r;
      @(posedge clk); #1;
      chk("coin_ack", bus.wb_ack_o, 1'b1);
      chk("coin_data", bus.wb_dat_o, exp);
      m_int = 1'b0;
      for (int i = 0; i < 4; i++) m_rx[i] = r[i*32 +: 32];
      m_busy = 1'b0;
      if (m_ie) m_int = 1'b1;
      chk("coin_int", bus.wb_int_o, m_int);
      chk("ass_after", ss_pad, 8'hFF);
      @(negedge clk);
      bus.wb_cyc_i = 0; bus.wb_stb_i = 0; done = 0;
      for (int i = 0; i < 4; i++) rd_chk(5'(i * 4));

      // done outside BUSY is ignored
      done_pulse(rand128());
      rd_chk(5'h04);

      // invalid / misaligned addresses
      wr_chk(5'h1C, 32'hFFFF_FFFF, 4'hF);
      chk("err_gone", bus.wb_err_o, 1'b0);
      rd_chk(5'h1C);
      wr_chk(5'h15, 32'hFFFF_FFFF, 4'hF);
      rd_chk(5'h14);
      rd_chk(5'h12);

      // randomized traffic against the model
      for (int it = 0; it < 60; it++) begin
         op = int'($urandom_range(0, 6));
         case (op)
            0: wr_chk(5'($urandom_range(0, 3) * 4), $urandom, 4'($urandom));
            1: wr_chk(5'h14, $urandom, 4'($urandom));
            2: wr_chk(5'h18, $urandom, 4'($urandom));
            3: begin
               adr = 5'($urandom);
               if ($urandom_range(0, 3) != 0) adr[1:0] = 2'b00;
               rd_chk(adr);
            end
            4: wr_chk(5'h10, $urandom & 32'hFFFF_FEFF, 4'($urandom));
            5: begin
               d = ($urandom & 32'h0000_3E7F) | 32'h0000_0100;
               wr_chk(5'h10, d, 4'hF);
               repeat ($urandom_range(0, 3)) begin
                  if ($urandom_range(0, 1) != 0) wr_chk(5'h14, $urandom, 4'hF);
                  else rd_chk(5'($urandom_range(0, 6) * 4));
               end
               chk_outs();
               done_pulse(rand128());
            end
            default: begin
               adr = 5'($urandom);
               if (adr[1:0] == 2'b00) adr = 5'h1C;
               wr_chk(adr, $urandom, 4'hF);
            end
         endcase
         chk_outs();
      end
      if (m_busy) done_pulse(rand128());

      // reset in the middle of a transfer
      wr_chk(5'h18, 32'h0000_00F0, 4'hF);
      wr_chk(5'h10, 32'h0000_3120, 4'hF);
      @(negedge clk);
      chk("pre_rst_ss", ss_pad, 8'h0F);
      #2 rst_n = 1'b0;
      #1;
      m_reset();
      chk("arst_go", go, 1'b0);
      chk("arst_ack", bus.wb_ack_o, 1'b0);
      chk("arst_int", bus.wb_int_o, 1'b0);
      chk("arst_dat", bus.wb_dat_o, 32'h0);
      chk_outs();
      @(negedge clk);
      rst_n = 1'b1;
      done_pulse(rand128());
      rd_chk(5'h00);
      rd_chk(5'h0C);
      rd_chk(5'h10);
      chk_outs();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
